debug_display: RTL and testbench

Four-digit multiplexed 7-segment driver for the debug board, directly downstream of the IR remote decoder. It consumes the decoder's `mode`, `showName` and `err` outputs, plus a 16-bit debug value that the CPU-side mux selects by `mode`. It shows either the value in hex or a short name identifying the selected mode. A mode change shows the name for a fixed hold time before reverting to the value.

---
 rtl/debug_display.sv | 133 +++++++++++++
 tb/tb_debug_display.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_display.sv
// Four-digit multiplexed 7-segment debug display.
// Shows the debug value in hex, or the mode name for a hold time after a mode change.
module debug_display #(
  parameter int REFRESH_DIV     = 50000,
  parameter int NAME_HOLD_TICKS = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic        showName,
  input  logic        err,
  input  logic [15:0] value,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int TW = $clog2(NAME_HOLD_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] HOLD    = TW'(NAME_HOLD_TICKS);

  localparam logic [4:0] C_D    = 5'd13;
  localparam logic [4:0] C_E    = 5'd14;
  localparam logic [4:0] C_DASH = 5'd16;
  localparam logic [4:0] C_R    = 5'd17;

  logic [DW-1:0] div;
  logic [1:0]    dig;
  logic [15:0]   valSnap;
  logic [3:0]    modePrev;
  logic          errPrev;
  logic [TW-1:0] nameTmr;
  logic [TW-1:0] errTmr;

  logic          tick;
  logic          nameMode;
  logic          badMode;
  logic [3:0]    units;
  logic [3:0]    nib;
  logic [4:0]    chr;
  logic          dp;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    logic [6:0] g;
    case (c)
      5'd0:    g = 7'h3F;
      5'd1:    g = 7'h06;
      5'd2:    g = 7'h5B;
      5'd3:    g = 7'h4F;
      5'd4:    g = 7'h66;
      5'd5:    g = 7'h6D;
      5'd6:    g = 7'h7D;
      5'd7:    g = 7'h07;
      5'd8:    g = 7'h7F;
      5'd9:    g = 7'h6F;
      5'd10:   g = 7'h77;
      5'd11:   g = 7'h7C;
      5'd12:   g = 7'h39;
      5'd13:   g = 7'h5E;
      5'd14:   g = 7'h79;
      5'd15:   g = 7'h71;
      5'd16:   g = 7'h40;
      5'd17:   g = 7'h50;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign tick = (div == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      dig     <= '0;
      valSnap <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) dig <= dig + 2'd1;
      if (tick && dig == 2'd3) valSnap <= value;
    end
  end

  // A fresh event reload takes priority over a same-cycle tick decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      modePrev <= '0;
      errPrev  <= 1'b0;
      nameTmr  <= '0;
      errTmr   <= '0;
    end else begin
      modePrev <= mode;
      errPrev  <= err;
      if (mode != modePrev)
        nameTmr <= HOLD;
      else if (tick && nameTmr != '0)
        nameTmr <= nameTmr - TW'(1);
      if (err && !errPrev)
        errTmr <= HOLD;
      else if (tick && errTmr != '0)
        errTmr <= errTmr - TW'(1);
    end
  end

  assign nameMode = showName || (nameTmr != '0);
  assign badMode  = (mode > 4'd10);
  assign units    = (mode >= 4'd10) ? mode - 4'd10 : mode;
  assign nib      = valSnap[{dig, 2'b00} +: 4];
  assign dp       = (dig == 2'd0) && (errTmr != '0);

  always_comb begin
    chr = {1'b0, nib};
    if (nameMode) begin
      unique case (dig)
        2'd3: chr = C_D;
        2'd2: chr = C_DASH;
        2'd1: chr = badMode ? C_E :
                    (mode >= 4'd10) ? 5'd1 : 5'd0;
        2'd0: chr = badMode ? C_R : {1'b0, units};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= ~{dp, glyph(chr)};
      an  <= ~(4'b0001 << dig);
    end
  end

endmodule

// File: tb/tb_debug_display.sv
// Self-checking bench for debug_display: directed vectors,
// corner-case sequences and randomized traffic against a reference model.
module tb_debug_display;

  localparam int R = 4;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mode = 4'd0;
  logic        showName = 1'b0;
  logic        err = 1'b0;
  logic [15:0] value = 16'h1A2F;
  logic [7:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  // Reference state: cycles since reset, ticks since last name/err event.
  int          cyc;
  int          nameSince;
  int          errSince;
  int          prevMode;
  logic        prevErr;
  logic [15:0] snap;
  logic [7:0]  mseg;
  logic [3:0]  man;

  logic [6:0] hexg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    string            nm;
    logic [3:0]       mode;
    logic             sn;
    logic [15:0]      value;
    int               pre;
    logic [3:0][7:0]  exp;
  } vec_t;

  vec_t vecs [7];

  debug_display #(
    .REFRESH_DIV(R),
    .NAME_HOLD_TICKS(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .showName(showName),
    .err(err),
    .value(value),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    int         d;
    bit         tk;
    bit         nm;
    bit         dpm;
    logic [6:0] g;
    int         m;
    if (rst) begin
      mseg = 8'hFF;
      man  = 4'hF;
      cyc = 0;
      nameSince = H;
      errSince = H;
      snap = 16'h0;
      prevMode = 0;
      prevErr = 1'b0;
    end else begin
      m  = int'(mode);
      d  = (cyc / R) % 4;
      tk = (cyc % R) == R - 1;
      nm = showName || nameSince < H;
      if (nm) begin
        case (d)
          3: g = 7'h5E;
          2: g = 7'h40;
          1: g = (m > 10) ? 7'h79 : hexg[m / 10];
          default: g = (m > 10) ? 7'h50 : hexg[m % 10];
        endcase
      end else begin
        g = hexg[(snap >> (4 * d)) & 16'hF];
      end
      dpm  = (d == 0) && errSince < H;
      mseg = ~{dpm, g};
      man  = 4'hF ^ (4'd1 << d);
      if (m != prevMode) nameSince = 0;
      else if (tk && nameSince < H) nameSince++;
      if (err && !prevErr) errSince = 0;
      else if (tk && errSince < H) errSince++;
      if (tk && d == 3) snap = value;
      prevMode = m;
      prevErr = err;
      cyc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_seg", {24'h0, seg}, {24'h0, mseg});
    chk("model_an", {28'h0, an}, {28'h0, man});
  endtask

  task automatic grab(output logic [3:0][7:0] f);
    f = '0;
    for (int i = 0; i < 4 * R; i++) begin
      step();
      for (int k = 0; k < 4; k++)
        if (an == (4'hF ^ (4'd1 << k))) f[k] = seg;
    end
  endtask

  task automatic wait_an(input logic [3:0] t, input string nm);
    int n = 0;
    while (an !== t && n < 8 * R) begin
      step();
      n++;
    end
    chk(nm, {28'h0, an}, {28'h0, t});
  endtask

  initial begin
    logic [3:0][7:0] f;
    vecs[0] = '{"value_1A2F", 4'd0, 1'b0, 16'h1A2F, 20,
                '{8'h06, 8'h77, 8'h5B, 8'h71}};
    vecs[1] = '{"name_d07", 4'd7, 1'b0, 16'h1A2F, 2,
                '{8'h5E, 8'h40, 8'h3F, 8'h07}};
    vecs[2] = '{"revert_07", 4'd7, 1'b0, 16'h1A2F, 40,
                '{8'h06, 8'h77, 8'h5B, 8'h71}};
    vecs[3] = '{"showname_d10", 4'd10, 1'b1, 16'h1A2F, 80,
                '{8'h5E, 8'h40, 8'h06, 8'h3F}};
    vecs[4] = '{"revert_10", 4'd10, 1'b0, 16'h1A2F, 40,
                '{8'h06, 8'h77, 8'h5B, 8'h71}};
    vecs[5] = '{"name_dEr", 4'd12, 1'b0, 16'h1A2F, 2,
                '{8'h5E, 8'h40, 8'h79, 8'h50}};
    vecs[6] = '{"revert_Er", 4'd12, 1'b0, 16'h1A2F, 40,
                '{8'h06, 8'h77, 8'h5B, 8'h71}};

    repeat (3) step();
    chk("reset_seg", {24'h0, seg}, 32'hFF);
    chk("reset_an", {28'h0, an}, 32'hF);
    rst = 1'b0;
    step();
    chk("first_an", {28'h0, an}, 32'hE);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      showName = vecs[i].sn;
      value = vecs[i].value;
      repeat (vecs[i].pre) step();
      grab(f);
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s_d%0d", vecs[i].nm, k),
            {24'h0, f[k]}, {24'h0, ~vecs[i].exp[k]});
    end

    err = 1'b1;
    repeat (3) step();
    err = 1'b0;
    repeat (17) step();
    err = 1'b1;
    step();
    err = 1'b0;
    repeat (16) step();
    wait_an(4'b1110, "wait_dp_on");
    chk("dp_extended", {31'h0, seg[7]}, 32'h0);
    wait_an(4'b0111, "wait_dig3");
    chk("dp_dig3_off", {31'h0, seg[7]}, 32'h1);
    repeat (20) step();
    wait_an(4'b1110, "wait_dp_off");
    chk("dp_expired", {31'h0, seg[7]}, 32'h1);

    value = 16'h1234;
    repeat (40) step();
    wait_an(4'b1101, "wait_tear_d1");
    chk("pre_tear_d1", {24'h0, seg}, {24'h0, ~8'h4F});
    value = 16'hABCD;
    wait_an(4'b1011, "wait_tear_d2");
    chk("tear_d2", {24'h0, seg}, {24'h0, ~8'h5B});
    wait_an(4'b0111, "wait_tear_d3");
    chk("tear_d3", {24'h0, seg}, {24'h0, ~8'h06});
    repeat (R) step();
    grab(f);
    chk("new_frame_d3", {24'h0, f[3]}, {24'h0, ~8'h77});
    chk("new_frame_d2", {24'h0, f[2]}, {24'h0, ~8'h7C});
    chk("new_frame_d1", {24'h0, f[1]}, {24'h0, ~8'h39});
    chk("new_frame_d0", {24'h0, f[0]}, {24'h0, ~8'h5E});

    wait_an(4'b1101, "wait_mid_rst");
    rst = 1'b1;
    step();
    chk("midrst_seg", {24'h0, seg}, 32'hFF);
    chk("midrst_an", {28'h0, an}, 32'hF);
    rst = 1'b0;
    step();
    chk("midrst_restart_an", {28'h0, an}, 32'hE);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 400) == 0;
      if (($urandom % 40) == 0) mode = 4'($urandom_range(0, 15));
      if (($urandom % 60) == 0) showName = ~showName;
      if (($urandom % 25) == 0) err = ~err;
      if (($urandom % 7) == 0) value = 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
